// File: rtl/img_pkg.sv
// Shared image constants and state encoding for the image reader/writer pair.
package img_pkg;

  localparam int unsigned IMG_WIDTH = 24;
  localparam int unsigned IMG_W     = 512;
  localparam int unsigned IMG_H     = 512;
  localparam int unsigned DEPTH     = IMG_W * IMG_H;
  localparam int unsigned ADDR_W    = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2
  } img_state_e;

  // Counter width for a range of n values; never returns zero.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imwrite_if.sv
// Pixel stream (valid/ready) between the processing pipeline and the frame sink.
interface imwrite_if #(
  parameter int unsigned IMG_WIDTH = img_pkg::IMG_WIDTH
);
  import img_pkg::*;

  logic [IMG_WIDTH-1:0] img_din;
  logic                 img_din_vld;
  logic                 img_din_rdy;

  modport master (output img_din, output img_din_vld, input  img_din_rdy);
  modport slave  (input  img_din, input  img_din_vld, output img_din_rdy);

endinterface

// File: rtl/img_raster_cnt.sv
// Raster position counters: column, line and linear frame-buffer address.
module img_raster_cnt
  import img_pkg::*;
#(
  parameter int unsigned IMG_W  = img_pkg::IMG_W,
  parameter int unsigned IMG_H  = img_pkg::IMG_H,
  parameter int unsigned ADDR_W = img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              eol,
  output logic              eof
);

  localparam int unsigned XW = cnt_w(IMG_W);
  localparam int unsigned YW = cnt_w(IMG_H);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign eol = (x == XW'(IMG_W - 1));
  assign eof = eol && (y == YW'(IMG_H - 1));

  // Advance in raster order; wrap everything to zero after the last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (inc) begin
      if (eof) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (eol) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imwrite.sv
// Frame-capture sink: writes one raster frame of pixels to the frame buffer,
// flags line/frame completion, accumulates a checksum and flags overruns.
module imwrite
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = img_pkg::IMG_WIDTH,
  parameter int unsigned IMG_W     = img_pkg::IMG_W,
  parameter int unsigned IMG_H     = img_pkg::IMG_H,
  parameter int unsigned ADDR_W    = img_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  imwrite_if.slave             pix,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [IMG_WIDTH-1:0] mem_wdata,
  output logic                 line_done,
  output logic                 frame_done,
  output logic [31:0]          frame_sum,
  output logic                 busy,
  output logic                 err_overrun
);

  img_state_e        state, state_nxt;
  logic              rdy;
  logic              hs;
  logic              start;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_eol;
  logic              cnt_eof;

  assign hs              = pix.img_din_vld & rdy;
  assign start           = frame_start && (state == IDLE);
  assign pix.img_din_rdy = rdy;

  img_raster_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .inc  (hs),
    .addr (cnt_addr),
    .eol  (cnt_eol),
    .eof  (cnt_eof)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and ready/busy decode.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = CAPTURE;
      CAPTURE: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (hs && cnt_eof) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write port, completion pulses, checksum and overrun flag.
  // The final write lands in FLUSH, so frame_done rides with it naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      err_overrun <= 1'b0;
    end else begin
      mem_we     <= hs;
      line_done  <= hs & cnt_eol;
      frame_done <= hs & cnt_eof;
      if (hs) begin
        mem_addr  <= cnt_addr;
        mem_wdata <= pix.img_din;
        frame_sum <= frame_sum + 32'(pix.img_din);
      end
      if (start) begin
        frame_sum   <= '0;
        err_overrun <= 1'b0;
      end else if (pix.img_din_vld && (state != CAPTURE)) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imwrite.sv
// Self-checking bench for imwrite on a 4x2 frame.
module tb_imwrite;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned D  = W * H;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          line_done;
  logic          frame_done;
  logic [31:0]   frame_sum;
  logic          busy;
  logic          err_overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          ld;
    logic          fd;
    logic [31:0]   sum;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_idx = 0;
  logic [31:0] exp_sum = '0;

  imwrite_if #(.IMG_WIDTH(24)) pix ();

  imwrite #(
    .IMG_WIDTH (24),
    .IMG_W     (W),
    .IMG_H     (H),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix         (pix.slave),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .line_done   (line_done),
    .frame_done  (frame_done),
    .frame_sum   (frame_sum),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #20 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Write monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_we: got write addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data || line_done !== e.ld ||
              frame_done !== e.fd || frame_sum !== e.sum) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h ld=%b fd=%b sum=%0d, expected addr=%0d data=%h ld=%b fd=%b sum=%0d",
                     mem_addr, mem_wdata, line_done, frame_done, frame_sum,
                     e.addr, e.data, e.ld, e.fd, e.sum);
          end
        end
      end else begin
        checks++;
        if (line_done !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL stray_pulse: got ld=%b fd=%b without write, expected 0 0", line_done, frame_done);
        end
      end
    end
  end

  task automatic drive_idle();
    @(negedge clk); #2;
    pix.img_din_vld = 1'b0;
    frame_start     = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk); #2;
    pix.img_din_vld = 1'b0;
    frame_start     = 1'b1;
    exp_idx         = 0;
    exp_sum         = '0;
    @(negedge clk); #2;
    frame_start     = 1'b0;
  endtask

  // Present one pixel after 'gap' idle cycles and hold it until accepted.
  task automatic send_pixel(input logic [23:0] d, input int gap, input logic fs);
    exp_t e;
    int   n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); #2;
      pix.img_din_vld = 1'b0;
      frame_start     = 1'b0;
    end
    @(negedge clk); #2;
    pix.img_din     = d;
    pix.img_din_vld = 1'b1;
    frame_start     = fs;
    n = 0;
    while (pix.img_din_rdy !== 1'b1 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    if (pix.img_din_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got rdy=%b after 20 cycles, expected 1", pix.img_din_rdy);
      return;
    end
    exp_sum = exp_sum + {8'h00, d};
    e.addr  = AW'(exp_idx);
    e.data  = d;
    e.ld    = (exp_idx % W) == (W - 1);
    e.fd    = exp_idx == (D - 1);
    e.sum   = exp_sum;
    sb.push_back(e);
    exp_idx++;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, line_done, frame_done, frame_sum, busy,
         err_overrun, pix.img_din_rdy} !== '0) begin
      errors++;
      $display("FAIL %s: got we=%b addr=%0d data=%h ld=%b fd=%b sum=%0d busy=%b err=%b rdy=%b, expected all 0",
               name, mem_we, mem_addr, mem_wdata, line_done, frame_done, frame_sum,
               busy, err_overrun, pix.img_din_rdy);
    end
  endtask

  task automatic check_idle_after(input string name);
    repeat (2) drive_idle();
    checks++;
    if (busy !== 1'b0 || pix.img_din_rdy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s: got busy=%b rdy=%b pending=%0d, expected 0 0 0",
               name, busy, pix.img_din_rdy, sb.size());
    end
  endtask

  task automatic test_reset();
    #5;
    check_quiet("reset_assert");
    #5 rst = 1'b0;
    repeat (2) drive_idle();
    check_quiet("reset_release");
  endtask

  task automatic test_full_frame();
    start_frame();
    checks++;
    if (busy !== 1'b1 || pix.img_din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL capture_entry: got busy=%b rdy=%b, expected 1 1", busy, pix.img_din_rdy);
    end
    for (int i = 1; i <= 8; i++) send_pixel(24'(i), 0, 1'b0);
    check_idle_after("full_frame_end");
    checks++;
    if (frame_sum !== 32'd36) begin
      errors++;
      $display("FAIL full_frame_sum: got %0d, expected 36", frame_sum);
    end
  endtask

  task automatic test_gapped();
    start_frame();
    for (int i = 1; i <= 8; i++) send_pixel(24'(i), 1, 1'b0);
    check_idle_after("gapped_end");
    checks++;
    if (frame_sum !== 32'd36) begin
      errors++;
      $display("FAIL gapped_sum: got %0d, expected 36", frame_sum);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk); #2;
    pix.img_din     = 24'hFFFFFF;
    pix.img_din_vld = 1'b1;
    drive_idle();
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, expected 1", err_overrun);
    end
    start_frame();
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, expected 0", err_overrun);
    end
    for (int i = 0; i < 8; i++) send_pixel(24'h100 + 24'(i), 0, 1'b0);
    check_idle_after("overrun_frame_end");
  endtask

  task automatic test_restart_ignore();
    start_frame();
    for (int i = 0; i < 8; i++) send_pixel(24'h20 + 24'(i), 0, i == 3);
    check_idle_after("restart_first_end");
    checks++;
    if (err_overrun !== 1'b0 || frame_sum !== 32'd284) begin
      errors++;
      $display("FAIL restart_first: got err=%b sum=%0d, expected 0 284", err_overrun, frame_sum);
    end
    start_frame();
    for (int i = 0; i < 8; i++) send_pixel(24'hABC000 + 24'(i), 0, 1'b0);
    check_idle_after("restart_second_end");
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    for (int i = 0; i < 6; i++) send_pixel(24'h55 + 24'(i), 0, 1'b0);
    drive_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_pending: got %0d pending writes, expected 0", sb.size());
    end
    sb.delete();
    #3 rst = 1'b1;
    #5;
    check_quiet("reset_mid_frame");
    #5 rst = 1'b0;
    start_frame();
    for (int i = 0; i < 8; i++) send_pixel(24'h300 + 24'(i), 0, 1'b0);
    check_idle_after("after_reset_frame_end");
  endtask

  initial begin
    pix.img_din     = '0;
    pix.img_din_vld = 1'b0;
    test_reset();
    test_full_frame();
    test_gapped();
    test_overrun();
    test_restart_ignore();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
